// File: rtl/limp_sequencer.sv
// rtl/limp_sequencer.sv - timed valve/pump sequencer for NADA/ADB/LIMP cleaning modes
// Outputs are registered from the next-state decode, so no input reaches an output combinationally.
module limp_sequencer #(
  parameter int CNT_W   = 8,
  parameter int T_DOSE  = 3,
  parameter int T_HOLD  = 2,
  parameter int T_DRAIN = 4,
  parameter int T_RINSE = 2,
  parameter int T_FILL  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       critico,
  input  logic       tick,
  output logic       valve_in,
  output logic       valve_out,
  output logic       pump_adb,
  output logic       busy,
  output logic       done,
  output logic       alarm,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADB_DOSE = 3'd1,
    S_ADB_HOLD = 3'd2,
    S_DRAIN    = 3'd3,
    S_RINSE    = 3'd4,
    S_FILL     = 3'd5,
    S_DONE     = 3'd6,
    S_ALARM    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] L_DOSE  = CNT_W'(T_DOSE - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] L_DRAIN = CNT_W'(T_DRAIN - 1);
  localparam logic [CNT_W-1:0] L_RINSE = CNT_W'(T_RINSE - 1);
  localparam logic [CNT_W-1:0] L_FILL  = CNT_W'(T_FILL - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_cnt;
  logic             timed;
  logic             phase_end;
  logic             want_adb, want_limp;

  assign want_adb  = (mode == 2'b01);
  assign want_limp = (mode == 2'b10);

  always_comb begin
    timed    = 1'b1;
    last_cnt = '0;
    case (state_q)
      S_ADB_DOSE: last_cnt = L_DOSE;
      S_ADB_HOLD: last_cnt = L_HOLD;
      S_DRAIN:    last_cnt = L_DRAIN;
      S_RINSE:    last_cnt = L_RINSE;
      S_FILL:     last_cnt = L_FILL;
      default:    timed    = 1'b0;
    endcase
    phase_end = timed && tick && (cnt_q == last_cnt);

    // Priority: critico, then abort (mode mismatch), then phase completion.
    state_d = state_q;
    if (critico) begin
      state_d = S_ALARM;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (want_adb)       state_d = S_ADB_DOSE;
          else if (want_limp) state_d = S_DRAIN;
        end
        S_ADB_DOSE: begin
          if (!want_adb)      state_d = S_IDLE;
          else if (phase_end) state_d = S_ADB_HOLD;
        end
        S_ADB_HOLD: begin
          if (!want_adb)      state_d = S_IDLE;
          else if (phase_end) state_d = S_DONE;
        end
        S_DRAIN: begin
          if (!want_limp)     state_d = S_IDLE;
          else if (phase_end) state_d = S_RINSE;
        end
        S_RINSE: begin
          if (!want_limp)     state_d = S_IDLE;
          else if (phase_end) state_d = S_FILL;
        end
        S_FILL: begin
          if (!want_limp)     state_d = S_IDLE;
          else if (phase_end) state_d = S_DONE;
        end
        S_DONE, S_ALARM: begin
          if (!want_adb && !want_limp) state_d = S_IDLE;
        end
      endcase
    end

    // Untimed states hold the counter at zero so it can never wrap while parked.
    if ((state_d != state_q) || !timed) cnt_d = '0;
    else if (tick)                      cnt_d = cnt_q + CNT_W'(1);
    else                                cnt_d = cnt_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      valve_in  <= 1'b0;
      valve_out <= 1'b0;
      pump_adb  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      alarm     <= 1'b0;
      phase     <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valve_in  <= (state_d == S_RINSE) || (state_d == S_FILL);
      valve_out <= (state_d == S_DRAIN) || (state_d == S_RINSE);
      pump_adb  <= (state_d == S_ADB_DOSE);
      busy      <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ALARM);
      done      <= (state_d == S_DONE);
      alarm     <= (state_d == S_ALARM);
      phase     <= state_d;
    end
  end

endmodule

// File: tb/tb_limp_sequencer.sv
// tb/tb_limp_sequencer.sv - directed self-checking bench for limp_sequencer
module tb_limp_sequencer;

  logic       clock;
  logic       reset;
  logic [1:0] mode;
  logic       critico;
  logic       tick;
  logic       valve_in, valve_out, pump_adb, busy, done, alarm;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  limp_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .critico   (critico),
    .tick      (tick),
    .valve_in  (valve_in),
    .valve_out (valve_out),
    .pump_adb  (pump_adb),
    .busy      (busy),
    .done      (done),
    .alarm     (alarm),
    .phase     (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected output vector {alarm,done,busy,pump_adb,valve_out,valve_in,phase} per state.
  function automatic logic [8:0] exp_out(input int ph);
    case (ph)
      0:       exp_out = {6'b000000, 3'd0};
      1:       exp_out = {6'b001100, 3'd1};
      2:       exp_out = {6'b001000, 3'd2};
      3:       exp_out = {6'b001010, 3'd3};
      4:       exp_out = {6'b001011, 3'd4};
      5:       exp_out = {6'b001001, 3'd5};
      6:       exp_out = {6'b010000, 3'd6};
      default: exp_out = {6'b100000, 3'd7};
    endcase
  endfunction

  task automatic chk(input string tag, input int ph);
    logic [8:0] obs;
    logic [8:0] expv;
    obs  = {alarm, done, busy, pump_adb, valve_out, valve_in, phase};
    expv = exp_out(ph);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Four idle cycles then a one-cycle tick: a tick every five cycles.
  task automatic do_tick();
    repeat (4) cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  // Runs n ticks expecting cur, with the n-th tick landing in nxt.
  task automatic run_phase(input string tag, input int n, input int cur, input int nxt);
    for (int i = 0; i < n; i++) begin
      do_tick();
      chk(tag, (i == n - 1) ? nxt : cur);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b0;
    mode    = 2'b10;
    critico = 1'b0;
    tick    = 1'b0;

    // Reset held with LIMP requested and ticks pulsing
    for (int i = 0; i < 6; i++) begin
      tick = i[0];
      cyc();
    end
    tick = 1'b0;
    chk("reset_hold", 0);
    mode  = 2'b00;
    reset = 1'b1;
    repeat (3) cyc();
    chk("reset_release_idle", 0);
    mode = 2'b11;
    repeat (2) cyc();
    chk("idle_mode11", 0);

    // Full cleaning cycle
    mode = 2'b10;
    cyc();
    chk("clean_enter_drain", 3);
    run_phase("clean_drain", 4, 3, 4);
    run_phase("clean_rinse", 2, 4, 5);
    run_phase("clean_fill", 4, 5, 6);
    do_tick();
    do_tick();
    chk("clean_done_hold", 6);
    mode = 2'b00;
    cyc();
    chk("clean_done_exit", 0);

    // ADB cycle, then held mode must not retrigger
    mode = 2'b01;
    cyc();
    chk("adb_enter_dose", 1);
    run_phase("adb_dose", 3, 1, 2);
    run_phase("adb_hold", 2, 2, 6);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      chk("adb_done_no_retrigger", 6);
    end
    mode = 2'b11;
    cyc();
    chk("adb_done_exit_mode11", 0);

    // Abort in RINSE, then counter restarts from zero
    mode = 2'b10;
    cyc();
    chk("abort_enter_drain", 3);
    run_phase("abort_drain", 4, 3, 4);
    do_tick();
    chk("abort_rinse_mid", 4);
    mode = 2'b00;
    cyc();
    chk("abort_to_idle", 0);
    mode = 2'b10;
    cyc();
    chk("restart_drain", 3);
    run_phase("restart_drain_full", 4, 3, 4);
    run_phase("restart_rinse", 2, 4, 5);

    // Critical override during FILL
    do_tick();
    chk("crit_fill_mid", 5);
    critico = 1'b1;
    cyc();
    chk("crit_alarm", 7);
    do_tick();
    chk("crit_alarm_stays_crit", 7);
    critico = 1'b0;
    do_tick();
    chk("crit_alarm_limp_held", 7);
    mode = 2'b01;
    cyc();
    chk("crit_alarm_adb_held", 7);
    mode = 2'b00;
    cyc();
    chk("crit_alarm_exit", 0);

    // critico beats phase completion on the final DRAIN tick
    mode = 2'b10;
    cyc();
    chk("coinc_crit_drain", 3);
    run_phase("coinc_crit_drain_ticks", 3, 3, 3);
    repeat (4) cyc();
    tick    = 1'b1;
    critico = 1'b1;
    cyc();
    tick    = 1'b0;
    critico = 1'b0;
    chk("coinc_crit_wins", 7);
    mode = 2'b00;
    cyc();
    chk("coinc_crit_exit", 0);

    // Abort beats phase completion on the final DRAIN tick
    mode = 2'b10;
    cyc();
    chk("coinc_abort_drain", 3);
    run_phase("coinc_abort_drain_ticks", 3, 3, 3);
    repeat (4) cyc();
    tick = 1'b1;
    mode = 2'b00;
    cyc();
    tick = 1'b0;
    chk("coinc_abort_wins", 0);

    // Asynchronous reset mid-sequence clears outputs without a clock edge
    mode = 2'b10;
    cyc();
    run_phase("async_drain", 4, 3, 4);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_abort", 0);
    mode = 2'b00;
    cyc();
    reset = 1'b1;
    cyc();
    chk("async_reset_release", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/limp_sequencer.md
Name: limp_sequencer

Overview:
- Downstream actuator stage for the 2-bit cleaning-mode code (00 NADA, 01 ADB, 10 LIMP).
- Converts the requested mode into timed valve and pump commands.
  - Fertilizer dosing: dose phase, then hold phase.
  - Cleaning: drain, rinse, fill.
- Phase durations are counted in tick pulses.
- A critical-level input overrides everything with a latched safe state.

Parameters:
- CNT_W, 8: phase counter width.
- T_DOSE, 3: ticks pump_adb stays on in ADB_DOSE.
- T_HOLD, 2: ticks of settle time in ADB_HOLD, all actuators off.
- T_DRAIN, 4: ticks in DRAIN.
- T_RINSE, 2: ticks in RINSE.
- T_FILL, 4: ticks in FILL.
- Legal range for every T_*: 1 to 2^CNT_W-1. A value of 0 is illegal and unsupported.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- mode  in  2  requested mode: 00 NADA, 01 ADB, 10 LIMP, 11 treated as NADA.
- critico  in  1  critical tank condition; forces ALARM.
- tick  in  1  one-cycle timebase enable pulse.
- valve_in  out  1  inlet valve open.
- valve_out  out  1  drain valve open.
- pump_adb  out  1  fertilizer dosing pump on.
- busy  out  1  a sequence is in progress (states 1–5).
- done  out  1  sequence completed; held until mode returns to NADA.
- alarm  out  1  ALARM state active.
- phase  out  3  encoded current state.

Behaviour:
- States and phase encoding: IDLE=0, ADB_DOSE=1, ADB_HOLD=2, DRAIN=3, RINSE=4, FILL=5, DONE=6, ALARM=7.
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - All outputs 0; phase=0.
  - Asserting reset mid-sequence aborts immediately with no done.
- Outputs are a Moore decode of the state register only. There is no combinational path from any input to any output.
- Actuator decode per state:
  - IDLE, ADB_HOLD, DONE, ALARM: all actuators off.
  - ADB_DOSE: pump_adb=1.
  - DRAIN: valve_out=1.
  - RINSE: valve_in=1 and valve_out=1.
  - FILL: valve_in=1.
- Transitions, evaluated on each rising edge in this priority order:
  1. critico=1 → ALARM from any state, including ALARM itself.
  2. ALARM → IDLE only when critico=0 and mode=00 (or 11) on the same edge. Otherwise stay in ALARM.
  3. IDLE:
     - mode=01 → ADB_DOSE.
     - mode=10 → DRAIN.
     - otherwise stay in IDLE.
  4. Abort rule:
     - ADB_DOSE or ADB_HOLD with mode≠01 → IDLE.
     - DRAIN, RINSE or FILL with mode≠10 → IDLE.
     - An aborted sequence never asserts done.
  5. Timed phases: on an edge where tick=1 and counter==T_x−1, advance:
     - ADB_DOSE → ADB_HOLD → DONE.
     - DRAIN → RINSE → FILL → DONE.
  6. DONE → IDLE when mode is 00 or 11. Any other mode holds DONE, so a persistent mode cannot retrigger the sequence.
- Counter:
  - Cleared to 0 on every state change.
  - Increments only on edges where tick=1 and the state is unchanged.
  - Width CNT_W; it never wraps, because the phase exits at T_x−1.
- Phase timing:
  - Each timed phase spans exactly T_x tick pulses after entry.
  - A tick coincident with the entry edge is not counted.
- Simultaneous events:
  - critico beats a phase completion and an abort on the same edge.
  - An abort beats a phase completion on the same edge.
- Consecutive ticks on adjacent cycles are legal; each one counts.

Test Plan:
- Reset check: reset=0 with mode=10, tick pulsing → all outputs 0, phase=0. Release reset with mode=00 → stays IDLE.
- Full cleaning cycle with defaults: mode=10, tick every 5 cycles →
  - phase runs 3 (valve_out), then 4 (both valves), then 5 (valve_in), then 6 (done=1).
  - Phases last 4, 2 and 4 ticks respectively.
  - done stays 1 until mode=00, then phase=0 one edge later.
- ADB cycle: mode=01 →
  - phase=1 with pump_adb=1 for exactly 3 ticks.
  - Then phase=2 with everything off for 2 ticks.
  - Then phase=6.
  - Holding mode=01 in DONE keeps phase=6; no second dose occurs.
- Abort: in RINSE, drop mode to 00 → next edge phase=0, valves closed, done=0. Counter restarts from 0 on the next mode=10.
- Critical override:
  - During FILL, critico=1 → next edge phase=7, alarm=1, valves closed.
  - critico=0 with mode=10 still applied → stays in ALARM.
  - mode=00 → phase=0.
- Coincident-event priority:
  - On the final DRAIN tick edge, assert critico=1 → ALARM, not RINSE.
  - Repeat with mode=00 instead of critico → IDLE, not RINSE.
